meas_channel_scheduler: RTL and testbench
=========================================

// Module: meas_channel_scheduler
// PURPOSE
//  Time-multiplexes one signal-measurement core (freq/duty/high/low, N-period averaging) across
//  NUM_CH input channels. Selects each enabled channel in turn, waits for mux settling, starts
//  the core, waits for its finish pulse or a timeout, and banks the results per channel.
//  The result bank is readable by the host register block. Sits between pin inputs and the core.
// PARAMETERS
//  NUM_CH          4           number of input channels (2..16)
//  CH_W            2           channel index width, $clog2(NUM_CH)
//  SETTLE_CYCLES   4           wait after mux switch before core start (>=2, covers core sync)
//  TIMEOUT_CYCLES  50_000_000  max cycles from core_enable to core_finish before abort
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous, active-low reset
//  sig_in       in   NUM_CH  raw channel inputs
//  ch_mask      in   NUM_CH  1 = channel included in sweep; latched at each sweep start
//  start        in   1       pulse: begin sweep (ignored while busy)
//  continuous   in   1       1 = restart sweep after completion; sampled at sweep end
//  stop         in   1       pulse: abort at any state, return to IDLE
//  busy         out  1       high from cycle after accepted start until IDLE
//  sweep_done   out  1       1-cycle pulse at end of each completed sweep
//  cur_ch       out  CH_W    channel currently muxed to core
//  ch_valid     out  NUM_CH  per-channel result valid
//  ch_timeout   out  NUM_CH  per-channel last measurement timed out
//  rd_ch        in   CH_W    host read index
//  rd_freq      out  26      banked freq[rd_ch], registered, 1-cycle latency
//  rd_duty      out  8       banked duty[rd_ch], same timing
//  rd_high      out  20      banked high_time[rd_ch], same timing
//  rd_low       out  20      banked low_time[rd_ch], same timing
//  core_sig     out  1       sig_in[cur_ch] (combinational mux)
//  core_enable  out  1       1-cycle start pulse to core
//  core_rst_n   out  1       active-low core reset; low 1 cycle on timeout/stop abort
//  core_busy    in   1       core busy
//  core_finish  in   1       core finish pulse; core results are valid the cycle after
//  core_freq/core_duty/core_high/core_low  in  26/8/20/20  core results
// BEHAVIOUR
//  Reset: all outputs 0 except core_rst_n=1; bank cleared; state IDLE; cur_ch=0.
//  FSM: IDLE -> SETTLE -> START -> WAIT -> CAPTURE -> NEXT -> (SETTLE | IDLE).
//  IDLE: start=1 latches ch_mask; if latched mask==0, pulse sweep_done next cycle, stay IDLE,
//   busy stays 0. Else cur_ch = lowest set bit, -> SETTLE.
//  SETTLE: count SETTLE_CYCLES cycles, -> START. START: core_enable=1 for exactly 1 cycle,
//   clear timeout counter, -> WAIT.
//  WAIT: core_finish -> CAPTURE. Counter reaches TIMEOUT_CYCLES -> core_rst_n=0 one cycle,
//   ch_timeout[cur_ch]=1, ch_valid[cur_ch]=0, bank entry unchanged, -> NEXT.
//  CAPTURE (cycle after finish): latch core_* into bank[cur_ch], ch_valid=1, ch_timeout=0.
//  NEXT: next set mask bit above cur_ch -> cur_ch, SETTLE. None above: pulse sweep_done;
//   continuous=1 -> re-latch ch_mask, lowest set bit, SETTLE (mask 0 -> IDLE); else IDLE.
//  stop has priority over all transitions: -> IDLE next cycle; if in START/WAIT, core_rst_n=0
//   one cycle; no sweep_done; bank/valid bits of completed channels retained.
//  start while busy: ignored. start and stop same cycle in IDLE: stop wins (stay IDLE).
//  core_finish outside WAIT: ignored. Valid/timeout bits persist across sweeps until overwritten.
//  Timeout counter 32-bit, saturating. Read port updates every cycle regardless of FSM state;
//   rd_ch==cur_ch during CAPTURE returns old value that cycle, new value next.
// STRUCTURE
//  meas_defs.vh: FSM state encodings, result widths (FREQ_W=26, DUTY_W=8, TIME_W=20).
//  Sub-module meas_next_channel: combinational "next set bit above index / lowest set bit"
//   finder with found flag; FSM, counters and result bank stay in this module.
// TESTING (core instantiated, CLK_FREQ=50 MHz, AVG_CYCLES=8, NUM_CH=4)
//  ch0=1 MHz 50%, mask=0001, start -> one sweep_done; rd ch0: freq=1_000_000, duty=50,
//   high=25, low=25; ch_valid=0001; busy low after sweep_done.
//  mask=1010, ch1=500 kHz 25%, ch3=2 MHz 50% -> cur_ch visits 1 then 3 only; ch1 freq=500_000,
//   duty=25; ch3 freq=2_000_000; core_enable pulses exactly twice.
//  TIMEOUT_CYCLES=1000, ch2 held 0, mask=0100 -> core_rst_n low 1 cycle ~1001 cycles after
//   core_enable; ch_timeout=0100, ch_valid[2]=0, sweep_done pulses.
//  continuous=1, mask=0011 -> sweep_done every sweep; clear continuous -> IDLE after next sweep.
//  stop during WAIT on ch1 -> IDLE next cycle, core_rst_n pulse, no sweep_done; ch0 data kept.
//  mask=0000 start -> sweep_done 1 cycle later, busy never high; start while busy ignored.

Source files
------------

// File: rtl/meas_channel_scheduler_pkg.sv
// Shared types for the measurement channel scheduler.
// FSM states, result widths and the banked result record.
package meas_channel_scheduler_pkg;

  localparam int FREQ_W = 26;
  localparam int DUTY_W = 8;
  localparam int TIME_W = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_NEXT
  } state_t;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUTY_W-1:0] duty;
    logic [TIME_W-1:0] high;
    logic [TIME_W-1:0] low;
  } meas_res_t;

endpackage

// File: rtl/meas_channel_scheduler_next_channel.sv
// Channel finder: lowest set bit of one mask, and
// next set bit strictly above an index in another.
module meas_channel_scheduler_next_channel #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] lo_mask,
  input  logic [NUM_CH-1:0] hi_mask,
  input  logic [CH_W-1:0]   idx,
  output logic              lo_found,
  output logic [CH_W-1:0]   lo_idx,
  output logic              hi_found,
  output logic [CH_W-1:0]   hi_idx
);

  // Scan downward so the last hit is the lowest qualifying bit.
  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (lo_mask[i]) begin
        lo_found = 1'b1;
        lo_idx   = CH_W'(i);
      end
      if (hi_mask[i] && (i > int'(idx))) begin
        hi_found = 1'b1;
        hi_idx   = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/meas_channel_scheduler.sv
// Sweeps enabled input channels through one shared
// measurement core and banks its results per channel.
module meas_channel_scheduler
  import meas_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = $clog2(NUM_CH),
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  output logic              busy,
  output logic              sweep_done,
  output logic [CH_W-1:0]   cur_ch,
  output logic [NUM_CH-1:0] ch_valid,
  output logic [NUM_CH-1:0] ch_timeout,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [FREQ_W-1:0] rd_freq,
  output logic [DUTY_W-1:0] rd_duty,
  output logic [TIME_W-1:0] rd_high,
  output logic [TIME_W-1:0] rd_low,
  output logic              core_sig,
  output logic              core_enable,
  output logic              core_rst_n,
  input  logic              core_busy,
  input  logic              core_finish,
  input  logic [FREQ_W-1:0] core_freq,
  input  logic [DUTY_W-1:0] core_duty,
  input  logic [TIME_W-1:0] core_high,
  input  logic [TIME_W-1:0] core_low
);

  localparam int DEPTH = 1 << CH_W;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [15:0]       settle_cnt_q;
  logic [31:0]       to_cnt_q;
  logic              done_q, done_d;
  logic              abort_d;
  logic              cap_en, to_hit;
  logic              lo_found, hi_found;
  logic [CH_W-1:0]   lo_idx, hi_idx;
  meas_res_t         bank_q [DEPTH];
  meas_res_t         rd_q;
  logic              unused_core_busy;

  assign unused_core_busy = core_busy;

  meas_channel_scheduler_next_channel #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_next (
    .lo_mask  (ch_mask),
    .hi_mask  (mask_q),
    .idx      (cur_ch_q),
    .lo_found (lo_found),
    .lo_idx   (lo_idx),
    .hi_found (hi_found),
    .hi_idx   (hi_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cur_ch_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      mask_q   <= mask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    mask_d      = mask_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    cap_en      = 1'b0;
    to_hit      = 1'b0;
    core_enable = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d = ch_mask;
          if (lo_found) begin
            cur_ch_d = lo_idx;
            state_d  = S_SETTLE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = S_START;
      end
      S_START: begin
        core_enable = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (core_finish) begin
          state_d = S_CAPTURE;
        end else if (to_cnt_q >= TO_LAST) begin
          to_hit  = 1'b1;
          abort_d = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_CAPTURE: begin
        cap_en  = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (hi_found) begin
          cur_ch_d = hi_idx;
          state_d  = S_SETTLE;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (continuous) begin
            mask_d = ch_mask;
            if (lo_found) begin
              cur_ch_d = lo_idx;
              state_d  = S_SETTLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything decided above.
    if (stop) begin
      state_d  = S_IDLE;
      cur_ch_d = cur_ch_q;
      mask_d   = mask_q;
      done_d   = 1'b0;
      cap_en   = 1'b0;
      to_hit   = 1'b0;
      abort_d  = (state_q == S_START) || (state_q == S_WAIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
      done_q       <= 1'b0;
      core_rst_n   <= 1'b1;
      ch_valid     <= '0;
      ch_timeout   <= '0;
      rd_q         <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      done_q     <= done_d;
      core_rst_n <= !abort_d;
      rd_q       <= bank_q[rd_ch];
      if (state_q == S_SETTLE && state_d == S_SETTLE)
        settle_cnt_q <= settle_cnt_q + 16'd1;
      else
        settle_cnt_q <= '0;
      if (state_q == S_START)
        to_cnt_q <= '0;
      else if (state_q == S_WAIT && to_cnt_q != '1)
        to_cnt_q <= to_cnt_q + 32'd1;
      if (cap_en) begin
        bank_q[cur_ch_q]     <= '{freq: core_freq, duty: core_duty,
                                  high: core_high, low: core_low};
        ch_valid[cur_ch_q]   <= 1'b1;
        ch_timeout[cur_ch_q] <= 1'b0;
      end
      if (to_hit) begin
        ch_valid[cur_ch_q]   <= 1'b0;
        ch_timeout[cur_ch_q] <= 1'b1;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign sweep_done = done_q;
  assign cur_ch     = cur_ch_q;
  assign core_sig   = sig_in[cur_ch_q];
  assign rd_freq    = rd_q.freq;
  assign rd_duty    = rd_q.duty;
  assign rd_high    = rd_q.high;
  assign rd_low     = rd_q.low;

endmodule

// File: tb/tb_meas_channel_scheduler.sv
// Bench for meas_channel_scheduler: a scripted fake core
// feeds random results; a per-channel model predicts the bank.
module tb_meas_channel_scheduler;
  import meas_channel_scheduler_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int TO  = 200;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH-1:0] sig_in, ch_mask, ch_valid, ch_timeout;
  logic start, continuous, stop, busy, sweep_done;
  logic [CW-1:0] cur_ch, rd_ch;
  logic [FREQ_W-1:0] rd_freq, core_freq;
  logic [DUTY_W-1:0] rd_duty, core_duty;
  logic [TIME_W-1:0] rd_high, rd_low, core_high, core_low;
  logic core_sig, core_enable, core_rst_n, core_busy, core_finish;

  always #5 clk = ~clk;

  meas_channel_scheduler #(
    .NUM_CH(NCH), .CH_W(CW), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ch_mask(ch_mask),
    .start(start), .continuous(continuous), .stop(stop),
    .busy(busy), .sweep_done(sweep_done), .cur_ch(cur_ch),
    .ch_valid(ch_valid), .ch_timeout(ch_timeout), .rd_ch(rd_ch),
    .rd_freq(rd_freq), .rd_duty(rd_duty), .rd_high(rd_high),
    .rd_low(rd_low), .core_sig(core_sig), .core_enable(core_enable),
    .core_rst_n(core_rst_n), .core_busy(core_busy),
    .core_finish(core_finish), .core_freq(core_freq),
    .core_duty(core_duty), .core_high(core_high), .core_low(core_low)
  );

  int n_err = 0;
  int n_checks = 0;

  logic [FREQ_W-1:0] m_freq [NCH];
  logic [DUTY_W-1:0] m_duty [NCH];
  logic [TIME_W-1:0] m_high [NCH];
  logic [TIME_W-1:0] m_low  [NCH];
  logic [NCH-1:0]    m_valid, m_to;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void plan(input logic [NCH-1:0] m);
    for (int i = 0; i < NCH; i++) if (m[i]) exp_q.push_back(i);
  endfunction

  task automatic read_all();
    for (int i = 0; i < NCH; i++) begin
      rd_ch = CW'(i);
      @(negedge clk);
      chk("rd_freq", 32'(rd_freq), 32'(m_freq[i]));
      chk("rd_duty", 32'(rd_duty), 32'(m_duty[i]));
      chk("rd_high", 32'(rd_high), 32'(m_high[i]));
      chk("rd_low",  32'(rd_low),  32'(m_low[i]));
    end
  endtask

  task automatic serve(input int n_done, input int dead_pct,
                       input int stop_k, input bit flip_start,
                       output int n_en, output int n_dn,
                       output bit busy_at_done);
    int since = 0;
    int lat = -1;
    int ch = 0;
    bit dead = 1'b0;
    bit finished = 1'b0;
    logic [FREQ_W-1:0] vf;
    logic [DUTY_W-1:0] vd;
    logic [TIME_W-1:0] vh, vl;
    n_en = 0;
    n_dn = 0;
    busy_at_done = 1'b0;
    for (int c = 0; c < 20000 && !finished; c++) begin
      @(negedge clk);
      start = 1'b0;
      core_finish = 1'b0;
      since++;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          core_finish = 1'b1;
          m_freq[ch] = vf; m_duty[ch] = vd;
          m_high[ch] = vh; m_low[ch] = vl;
          m_valid[ch] = 1'b1; m_to[ch] = 1'b0;
          lat = -1;
        end
      end
      if (dead && !core_rst_n) begin
        chk("timeout_delay", since, TO + 1);
        m_valid[ch] = 1'b0; m_to[ch] = 1'b1;
        dead = 1'b0;
      end else if (!dead) begin
        chk("core_rst_n_idle", 32'(core_rst_n), 1);
      end
      if (core_enable) begin
        if (exp_q.size() == 0) begin
          chk("extra_enable", 1, 0);
          ch = 0;
        end else begin
          ch = exp_q.pop_front();
          chk("enable_ch", 32'(cur_ch), ch);
        end
        chk("core_sig", 32'(core_sig), 32'(sig_in[ch]));
        n_en++;
        since = 0;
        vf = FREQ_W'($urandom); vd = DUTY_W'($urandom);
        vh = TIME_W'($urandom); vl = TIME_W'($urandom);
        core_freq = vf; core_duty = vd;
        core_high = vh; core_low = vl;
        dead = (n_en - 1 == stop_k) ||
               (int'($urandom_range(99)) < dead_pct);
        lat = dead ? -1 : int'($urandom_range(30, 1));
        if (flip_start && n_en == 1) begin
          start = 1'b1;
          ch_mask = 4'hF;
        end
      end
      if (stop_k >= 0 && n_en == stop_k + 1 && since == 5) begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_core_rst", 32'(core_rst_n), 0);
        chk("stop_no_done", 32'(sweep_done), 0);
        @(negedge clk);
        chk("stop_core_rst_rel", 32'(core_rst_n), 1);
        finished = 1'b1;
      end else if (sweep_done) begin
        n_dn++;
        busy_at_done = busy;
        if (n_dn == n_done) finished = 1'b1;
      end
      sig_in = NCH'($urandom);
    end
    if (!finished) chk("cycle_budget", 0, 1);
  endtask

  initial begin
    int en, dn, extra;
    bit bz;
    rst_n = 1'b0;
    sig_in = '0; ch_mask = '0; start = 1'b0; continuous = 1'b0;
    stop = 1'b0; rd_ch = '0; core_busy = 1'b0; core_finish = 1'b0;
    core_freq = '0; core_duty = '0; core_high = '0; core_low = '0;
    m_valid = '0; m_to = '0;
    for (int i = 0; i < NCH; i++) begin
      m_freq[i] = '0; m_duty[i] = '0; m_high[i] = '0; m_low[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(sweep_done), 0);
    chk("rst_cur_ch", 32'(cur_ch), 0);
    chk("rst_valid", 32'(ch_valid), 0);
    chk("rst_timeout", 32'(ch_timeout), 0);
    chk("rst_core_en", 32'(core_enable), 0);
    chk("rst_core_rst_n", 32'(core_rst_n), 1);
    chk("rst_rd_freq", 32'(rd_freq), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single channel
    ch_mask = 4'b0001; start = 1'b1; plan(4'b0001);
    serve(1, 0, -1, 1'b0, en, dn, bz);
    chk("t1_enables", en, 1);
    chk("t1_busy_done", 32'(bz), 0);
    chk("t1_valid", 32'(ch_valid), 32'(m_valid));
    read_all();

    // sparse mask, start while busy ignored
    @(negedge clk);
    ch_mask = 4'b1010; start = 1'b1; plan(4'b1010);
    serve(1, 0, -1, 1'b1, en, dn, bz);
    chk("t2_enables", en, 2);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (sweep_done || core_enable) extra++;
    end
    chk("t2_no_restart", extra, 0);
    chk("t2_idle", 32'(busy), 0);
    read_all();

    // timeout on ch2
    ch_mask = 4'b0100; start = 1'b1; plan(4'b0100);
    serve(1, 100, -1, 1'b0, en, dn, bz);
    chk("t3_timeout", 32'(ch_timeout), 32'(m_to));
    chk("t3_timeout_ch2", 32'(ch_timeout[2]), 1);
    chk("t3_valid", 32'(ch_valid), 32'(m_valid));
    read_all();

    // continuous sweeps
    continuous = 1'b1; ch_mask = 4'b0011; start = 1'b1;
    plan(4'b0011); plan(4'b0011);
    serve(1, 0, -1, 1'b0, en, dn, bz);
    chk("t4_busy_cont", 32'(bz), 1);
    continuous = 1'b0;
    serve(1, 0, -1, 1'b0, en, dn, bz);
    chk("t4_enables2", en, 2);
    chk("t4_busy_end", 32'(bz), 0);
    chk("t4_valid", 32'(ch_valid), 32'(m_valid));

    // stop while waiting on ch1
    @(negedge clk);
    ch_mask = 4'b0011; start = 1'b1; plan(4'b0011);
    serve(1, 0, 1, 1'b0, en, dn, bz);
    exp_q.delete();
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (sweep_done || busy) extra++;
    end
    chk("t5_quiet", extra, 0);
    chk("t5_valid", 32'(ch_valid), 32'(m_valid));
    read_all();

    // empty mask
    ch_mask = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_done", 32'(sweep_done), 1);
    chk("t6_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t6_done_pulse", 32'(sweep_done), 0);
    chk("t6_busy2", 32'(busy), 0);

    // start and stop together
    ch_mask = 4'b1111; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t7_busy", 32'(busy), 0);
    chk("t7_done", 32'(sweep_done), 0);

    // random sweeps
    for (int s = 0; s < 12; s++) begin
      logic [NCH-1:0] m;
      @(negedge clk);
      m = NCH'($urandom_range(15, 1));
      ch_mask = m; start = 1'b1; plan(m);
      serve(1, 25, -1, 1'b0, en, dn, bz);
      chk("rnd_enables", en, $countones(m));
      chk("rnd_busy_done", 32'(bz), 0);
      chk("rnd_valid", 32'(ch_valid), 32'(m_valid));
      chk("rnd_timeout", 32'(ch_timeout), 32'(m_to));
      read_all();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
